coin_dispenser: RTL and testbench

Coin-side transmitter for the Lab5 coin acceptor protocol. It takes a requested credit amount, breaks it greedily into coins, and emits them on the same `CoinValue`/`CoinInserted` interface the acceptor FSM consumes. It sits in the lab bench/demo harness as an automated coin source, so game sequences can be driven without hand-written pulse trains.

---
 rtl/coin_dispenser.sv | 114 +++++++++++
 tb/tb_coin_dispenser.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/coin_dispenser.sv
// Automated coin source for the Lab5 acceptor: splits a requested credit greedily
// into 5/3/1-unit coins and emits them as CoinValue/CoinInserted pulses.
module coin_dispenser #(
  parameter int GAP = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [5:0] amount,
  input  logic       request,
  input  logic       hold,
  output logic [1:0] CoinValue,
  output logic       CoinInserted,
  output logic       busy,
  output logic       done,
  output logic [3:0] coinsIssued
);

  localparam int GW = (GAP < 1) ? 1 : $clog2(GAP + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_GAP,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [5:0]      rem_q, rem_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [1:0]      coin_q, coin_d;
  logic [3:0]      coins_q, coins_d;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      gap_cnt_q <= '0;
      coin_q    <= '0;
      coins_q   <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      gap_cnt_q <= gap_cnt_d;
      coin_q    <= coin_d;
      coins_q   <= coins_d;
    end
  end

  // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    gap_cnt_d = gap_cnt_q;
    coin_d    = coin_q;
    coins_d   = coins_q;

    unique case (state_q)
      S_IDLE: begin
        if (request) begin
          rem_d   = amount;
          coins_d = '0;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        // An exhausted balance finishes even while downstream is holding.
        if (rem_q == 6'd0) begin
          state_d = S_DONE;
        end else if (!hold) begin
          if (rem_q >= 6'd5) begin
            coin_d = 2'b11;
            rem_d  = rem_q - 6'd5;
          end else if (rem_q >= 6'd3) begin
            coin_d = 2'b10;
            rem_d  = rem_q - 6'd3;
          end else begin
            coin_d = 2'b01;
            rem_d  = rem_q - 6'd1;
          end
          coins_d = coins_q + 4'd1;
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (GAP == 0) begin
          state_d = S_LOAD;
        end else begin
          gap_cnt_d = GW'(GAP);
          state_d   = S_GAP;
        end
      end

      S_GAP: begin
        gap_cnt_d = gap_cnt_q - GW'(1);
        if (gap_cnt_q == GW'(1)) state_d = S_LOAD;
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  assign CoinInserted = (state_q == S_ISSUE);
  assign CoinValue    = (state_q == S_ISSUE) ? coin_q : 2'b00;
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign coinsIssued  = coins_q;

endmodule

// File: tb/tb_coin_dispenser.sv
// Randomized self-checking bench for coin_dispenser: a timeline model derived from the
// greedy coin rule and the coin period predicts every output cycle by cycle.
module tb_coin_dispenser;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] amount = '0;
  logic       req2 = 1'b0, hold2 = 1'b0;
  logic       req0 = 1'b0, hold0 = 1'b0;

  logic [1:0] cv2, cv0;
  logic       ci2, ci0, busy2, busy0, done2, done0;
  logic [3:0] cnt2, cnt0;

  int total = 0;
  int bad = 0;
  bit hold_at[400];

  always #5 clock = ~clock;

  coin_dispenser #(.GAP(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .amount(amount), .request(req2), .hold(hold2),
    .CoinValue(cv2), .CoinInserted(ci2), .busy(busy2), .done(done2), .coinsIssued(cnt2)
  );

  coin_dispenser #(.GAP(0)) dut0 (
    .clock(clock), .reset_n(reset_n), .amount(amount), .request(req0), .hold(hold0),
    .CoinValue(cv0), .CoinInserted(ci0), .busy(busy0), .done(done0), .coinsIssued(cnt0)
  );

  function automatic int units(input logic [1:0] code);
    case (code)
      2'b01:   return 1;
      2'b10:   return 3;
      2'b11:   return 5;
      default: return 0;
    endcase
  endfunction

  task automatic clear_hold();
    for (int i = 0; i < 400; i++) hold_at[i] = 1'b0;
  endtask

  // Runs one transaction on the chosen instance and checks every cycle from E0 until idle.
  // hold_at[k] is the hold level sampled at edge Ek; spur_at re-asserts request (amount 5) at that edge.
  task automatic run_txn(input bit g0, input int amt, input int spur_at, input string name);
    logic [1:0] coins[$];
    int pulse[$];
    int r, t, p, done_e, nc, sum_obs;
    logic [8:0] act, exp_v;
    logic [1:0] exp_cv;
    logic exp_ci;

    r = amt;
    while (r > 0) begin
      if (r >= 5)      begin coins.push_back(2'b11); r -= 5; end
      else if (r >= 3) begin coins.push_back(2'b10); r -= 3; end
      else             begin coins.push_back(2'b01); r -= 1; end
    end
    p = g0 ? 2 : 4;
    t = 1;
    foreach (coins[i]) begin
      while (hold_at[t]) t++;
      pulse.push_back(t);
      t += p;
    end
    done_e  = t;
    sum_obs = 0;

    amount = 6'(amt);
    if (g0) req0 = 1'b1; else req2 = 1'b1;
    @(posedge clock);
    #1;
    for (int k = 0; k <= done_e + 1; k++) begin
      if (g0) begin
        hold0 = hold_at[k + 1];
        req0  = (k + 1 == spur_at) && (spur_at <= done_e + 1);
      end else begin
        hold2 = hold_at[k + 1];
        req2  = (k + 1 == spur_at) && (spur_at <= done_e + 1);
      end
      amount = (k + 1 == spur_at) ? 6'd5 : 6'($urandom_range(0, 63));
      @(negedge clock);
      exp_ci = 1'b0;
      exp_cv = 2'b00;
      nc = 0;
      foreach (pulse[i]) begin
        if (pulse[i] == k) begin exp_ci = 1'b1; exp_cv = coins[i]; end
        if (pulse[i] <= k) nc++;
      end
      exp_v = {exp_cv, exp_ci, (k <= done_e), (k == done_e), 4'(nc)};
      act = g0 ? {cv0, ci0, busy0, done0, cnt0} : {cv2, ci2, busy2, done2, cnt2};
      if (act[6]) sum_obs += units(act[8:7]);
      total++;
      if (act !== exp_v) begin
        bad++;
        $display("FAIL %s amt=%0d cyc=E%0d: got cv=%b ci=%b busy=%b done=%b cnt=%0d, want cv=%b ci=%b busy=%b done=%b cnt=%0d",
                 name, amt, k, act[8:7], act[6], act[5], act[4], act[3:0],
                 exp_v[8:7], exp_v[6], exp_v[5], exp_v[4], exp_v[3:0]);
      end
      @(posedge clock);
      #1;
    end
    req0 = 1'b0; req2 = 1'b0; hold0 = 1'b0; hold2 = 1'b0;
    total++;
    if (sum_obs !== amt) begin
      bad++;
      $display("FAIL %s credit: delivered=%0d requested=%0d", name, sum_obs, amt);
    end
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({cv2, ci2, busy2, done2, cnt2, cv0, ci0, busy0, done0, cnt0} !== 18'd0) begin
      bad++;
      $display("FAIL reset_state: got %b/%b, want all zero",
               {cv2, ci2, busy2, done2, cnt2}, {cv0, ci0, busy0, done0, cnt0});
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic test_basic();
    clear_hold();
    run_txn(1'b0, 9, 0, "basic9");
  endtask

  task automatic test_empty();
    clear_hold();
    for (int i = 0; i < 6; i++) hold_at[i] = 1'b1;
    run_txn(1'b0, 0, 0, "empty");
  endtask

  task automatic test_hold();
    clear_hold();
    for (int i = 0; i <= 4; i++) hold_at[i] = 1'b1;
    run_txn(1'b0, 4, 0, "hold4");
  endtask

  task automatic test_ignore_request();
    clear_hold();
    run_txn(1'b0, 6, 3, "ignore_req");
  endtask

  task automatic test_max_gap0();
    clear_hold();
    run_txn(1'b1, 63, 0, "max63_gap0");
  endtask

  task automatic test_reset_abort();
    logic [8:0] act;
    int stray;
    clear_hold();
    amount = 6'd10;
    req2 = 1'b1;
    @(posedge clock);
    #1;
    req2 = 1'b0;
    @(negedge clock);
    @(negedge clock);
    total++;
    if ({cv2, ci2, cnt2} !== {2'b11, 1'b1, 4'd1}) begin
      bad++;
      $display("FAIL abort_first_coin: got cv=%b ci=%b cnt=%0d, want cv=11 ci=1 cnt=1", cv2, ci2, cnt2);
    end
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    act = {cv2, ci2, busy2, done2, cnt2};
    total++;
    if (act !== 9'd0) begin
      bad++;
      $display("FAIL abort_immediate: got %b want 000000000", act);
    end
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    stray = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (ci2 || done2 || busy2) stray++;
    end
    total++;
    if (stray !== 0) begin
      bad++;
      $display("FAIL abort_quiet: got %0d active cycles after release, want 0", stray);
    end
    @(posedge clock);
    #1;
    run_txn(1'b0, 1, 0, "after_abort");
  endtask

  task automatic test_back_to_back();
    clear_hold();
    run_txn(1'b0, $urandom_range(1, 63), 0, "b2b_a");
    run_txn(1'b0, $urandom_range(1, 63), 0, "b2b_b");
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      clear_hold();
      for (int i = 0; i < 60; i++) hold_at[i] = ($urandom_range(0, 3) == 0);
      run_txn(1'($urandom_range(0, 1)), $urandom_range(0, 63), $urandom_range(1, 40), "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_hold();
    test_reset_abort();
    test_ignore_request();
    test_max_gap0();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
